// File: rtl/dmem_sched_pkg.sv
// Shared types for the dual-port data-memory scheduler: FSM states, conflict
// classes, the held-operation record and the address range helper.
package dmem_sched_pkg;

  localparam int DATA_W           = 16;
  localparam int MEM_SIZE_DEFAULT = 512;

  typedef enum logic {IDLE, HOLD} state_e;

  typedef enum logic [2:0] {NONE, WW_SAME, WR_FWD, RR_SAME, SPLIT} conflict_e;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_op_t;

  function automatic logic in_range(input logic [DATA_W-1:0] addr, input int size);
    return 32'(addr) < 32'(size);
  endfunction

endpackage

// File: rtl/dmem_conflict_detect.sv
// Classifies a pair of same-cycle, in-range requests (pipe 0 older) into the
// conflict class that decides port assignment, forwarding or a split.
module dmem_conflict_detect
  import dmem_sched_pkg::*;
(
  input  logic              v0,
  input  logic              we0,
  input  logic [DATA_W-1:0] addr0,
  input  logic              v1,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr1,
  output conflict_e         conflict
);

  always_comb begin
    conflict = NONE;
    if (v0 && v1) begin
      if (addr0 == addr1) begin
        case ({we0, we1})
          2'b11:   conflict = WW_SAME;
          2'b10:   conflict = WR_FWD;
          2'b00:   conflict = RR_SAME;
          default: conflict = SPLIT;
        endcase
      end else if (!we0 && !we1) begin
        // Only one read strobe may be active per cycle.
        conflict = SPLIT;
      end
    end
  end

endmodule

// File: rtl/dmem_port_scheduler.sv
// Schedules two pipe requests onto a dual-port data memory, resolving
// same-cycle conflicts by merging, forwarding or splitting into a HOLD cycle.
module dmem_port_scheduler
  import dmem_sched_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [DATA_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [DATA_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] mem_address0,
  output logic [DATA_W-1:0] mem_address1,
  output logic              mem_read0,
  output logic              mem_read1,
  output logic              mem_write0,
  output logic              mem_write1,
  output logic [DATA_W-1:0] mem_wdata0,
  output logic [DATA_W-1:0] mem_wdata1,
  input  logic [DATA_W-1:0] mem_rdata0,
  input  logic [DATA_W-1:0] mem_rdata1
);

  state_e            state, state_nxt;
  conflict_e         conflict;
  mem_op_t           hold_op, op0, op1;
  logic              hold_vld;
  logic              acc0, acc1, inr0, inr1, go0, go1;
  logic              issue0, issue1;
  logic [DATA_W-1:0] rdata1_idle;

  assign req0_ready = reset && (state == IDLE);
  assign req1_ready = reset && (state == IDLE);
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign inr0       = in_range(req0_addr, MEM_SIZE);
  assign inr1       = in_range(req1_addr, MEM_SIZE);
  assign go0        = acc0 && inr0;
  assign go1        = acc1 && inr1;

  dmem_conflict_detect u_detect (
    .v0       (go0),
    .we0      (req0_we),
    .addr0    (req0_addr),
    .v1       (go1),
    .we1      (req1_we),
    .addr1    (req1_addr),
    .conflict (conflict)
  );

  always_comb begin
    state_nxt = state;
    issue0    = 1'b0;
    issue1    = 1'b0;
    op0       = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
    op1       = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
    if (state == IDLE) begin
      if (conflict == SPLIT) state_nxt = HOLD;
      issue0 = go0 && (conflict != WW_SAME);
      issue1 = go1 && ((conflict == NONE) || (conflict == WW_SAME));
    end else begin
      state_nxt = IDLE;
      issue1    = reset && hold_vld;
      op1       = hold_op;
    end
  end

  assign mem_read0    = issue0 && !op0.we;
  assign mem_write0   = issue0 && op0.we;
  assign mem_address0 = issue0 ? op0.addr : '0;
  assign mem_wdata0   = mem_write0 ? op0.wdata : '0;
  assign mem_read1    = issue1 && !op1.we;
  assign mem_write1   = issue1 && op1.we;
  assign mem_address1 = issue1 ? op1.addr : '0;
  assign mem_wdata1   = mem_write1 ? op1.wdata : '0;

  always_comb begin
    rdata1_idle = '0;
    if (go1 && !req1_we) begin
      case (conflict)
        WR_FWD:  rdata1_idle = req0_wdata;
        RR_SAME: rdata1_idle = mem_rdata0;
        SPLIT:   rdata1_idle = '0;
        default: rdata1_idle = mem_rdata1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- response stage: one cycle after issue ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_vld   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else if (state == IDLE) begin
      hold_vld   <= (conflict == SPLIT);
      rsp0_valid <= acc0;
      rsp0_rdata <= (go0 && !req0_we) ? mem_rdata0 : '0;
      rsp0_err   <= acc0 && !inr0;
      rsp1_valid <= acc1 && (conflict != SPLIT);
      rsp1_rdata <= rdata1_idle;
      rsp1_err   <= acc1 && !inr1;
    end else begin
      hold_vld   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= hold_vld;
      rsp1_rdata <= (hold_vld && !hold_op.we) ? mem_rdata1 : '0;
      rsp1_err   <= 1'b0;
    end
  end

  // Held payload carries no reset; hold_vld qualifies it.
  always_ff @(posedge clock) begin
    if (state == IDLE && conflict == SPLIT) hold_op <= op1;
  end

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// Bench for dmem_port_scheduler: directed vector table, reset corner cases and
// random pairs checked against a sequential program-order memory model.
module tb_dmem_port_scheduler;

  localparam int MEM_SIZE = 512;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [15:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [15:0] rsp0_rdata, rsp1_rdata;
  logic [15:0] mem_address0, mem_address1, mem_wdata0, mem_wdata1, mem_rdata0, mem_rdata1;
  logic        mem_read0, mem_read1, mem_write0, mem_write1;

  int tests = 0;
  int fails = 0;

  dmem_port_scheduler #(.MEM_SIZE(MEM_SIZE)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_address0(mem_address0), .mem_address1(mem_address1),
    .mem_read0(mem_read0), .mem_read1(mem_read1),
    .mem_write0(mem_write0), .mem_write1(mem_write1),
    .mem_wdata0(mem_wdata0), .mem_wdata1(mem_wdata1),
    .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1)
  );

  always #5 clock = ~clock;

  // Attached memory: combinational read, write on the rising edge.
  logic [15:0] mem [0:MEM_SIZE-1];
  logic        do_init = 1'b0;

  function automatic logic [15:0] init_val(input int i);
    if (i == 4) return 16'h0F0F;
    if (i == 5) return 16'h1111;
    if (i == 9) return 16'h2222;
    return 16'(i * 3 + 'h100);
  endfunction

  always @(posedge clock) begin
    if (do_init) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_write0 && mem_address0 < 16'(MEM_SIZE)) mem[mem_address0[8:0]] <= mem_wdata0;
      if (mem_write1 && mem_address1 < 16'(MEM_SIZE)) mem[mem_address1[8:0]] <= mem_wdata1;
    end
  end

  assign mem_rdata0 = (mem_address0 < 16'(MEM_SIZE)) ? mem[mem_address0[8:0]] : 16'h0;
  assign mem_rdata1 = (mem_address1 < 16'(MEM_SIZE)) ? mem[mem_address1[8:0]] : 16'h0;

  always @(negedge clock) begin
    if (reset) begin
      tests++;
      if (mem_read0 && mem_read1) begin
        fails++;
        $display("FAIL dual_read: read0=%0b read1=%0b, required not both 1 at %0t", mem_read0, mem_read1, $time);
      end
    end
  end

  typedef struct {
    bit          v0, we0;
    logic [15:0] a0, d0;
    bit          v1, we1;
    logic [15:0] a1, d1;
    logic [3:0]  strb;   // {read0, write0, read1, write1} in the accept cycle
    bit          split;
    logic [15:0] x0;
    bit          e0;
    logic [15:0] x1;
    bit          e1;
    logic [15:0] ca, cv; // memory word to inspect afterwards
  } vec_t;

  vec_t        tbl [13];
  logic [15:0] model_mem [0:MEM_SIZE-1];

  function automatic vec_t mk(bit v0, bit we0, logic [15:0] a0, logic [15:0] d0,
                              bit v1, bit we1, logic [15:0] a1, logic [15:0] d1,
                              logic [3:0] strb, bit split, logic [15:0] x0, bit e0,
                              logic [15:0] x1, bit e1, logic [15:0] ca, logic [15:0] cv);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.strb = strb; v.split = split;
    v.x0 = x0; v.e0 = e0; v.x1 = x1; v.e1 = e1; v.ca = ca; v.cv = cv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic init_mem();
    do_init = 1'b1;
    @(posedge clock); #1;
    do_init = 1'b0;
  endtask

  // Called one time unit after a rising edge with the DUT idle.
  task automatic do_txn(input vec_t v, input bit chk_strb, input string nm);
    req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_wdata = v.d1;
    #1;
    chk({nm, ".ready"}, {req0_ready, req1_ready}, 2'b11);
    if (chk_strb) chk({nm, ".strobes"}, {mem_read0, mem_write0, mem_read1, mem_write1}, v.strb);
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({nm, ".rsp0_valid"}, rsp0_valid, v.v0);
    if (v.v0) chk({nm, ".rsp0"}, {rsp0_err, rsp0_rdata}, {v.e0, v.x0});
    if (v.split) begin
      chk({nm, ".hold_ready"}, {req0_ready, req1_ready, rsp1_valid}, 3'b000);
      chk({nm, ".hold_strobes"}, {mem_read0, mem_write0, mem_read1, mem_write1, mem_address1},
          {2'b00, !v.we1, v.we1, v.a1});
      @(posedge clock); #1;
      chk({nm, ".rsp0_pulse"}, rsp0_valid, 1'b0);
    end
    chk({nm, ".rsp1_valid"}, rsp1_valid, v.v1);
    if (v.v1) chk({nm, ".rsp1"}, {rsp1_err, rsp1_rdata}, {v.e1, v.x1});
    @(posedge clock); #1;
    chk({nm, ".rsp_end"}, {rsp0_valid, rsp1_valid}, 2'b00);
  endtask

  // Program-order semantics: pipe 0 completes entirely before pipe 1.
  function automatic void model_txn(inout vec_t v);
    bit in0, in1;
    in0 = v.a0 < 16'(MEM_SIZE);
    in1 = v.a1 < 16'(MEM_SIZE);
    v.x0 = '0; v.e0 = 1'b0; v.x1 = '0; v.e1 = 1'b0;
    if (v.v0) begin
      if (!in0)       v.e0 = 1'b1;
      else if (v.we0) model_mem[v.a0[8:0]] = v.d0;
      else            v.x0 = model_mem[v.a0[8:0]];
    end
    if (v.v1) begin
      if (!in1)       v.e1 = 1'b1;
      else if (v.we1) model_mem[v.a1[8:0]] = v.d1;
      else            v.x1 = model_mem[v.a1[8:0]];
    end
    v.split = v.v0 && v.v1 && in0 && in1 && !v.we0 && ((v.a0 == v.a1) ? v.we1 : !v.we1);
  endfunction

  function automatic logic [15:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return 16'(500 + $urandom_range(0, 24));
    return 16'($urandom_range(0, 7));
  endfunction

  initial begin
    //            v0 we0 a0   d0      v1 we1 a1   d1      strb     sp x0       e0 x1       e1 ca   cv
    tbl[0]  = mk(1, 0, 5,   0,       1, 0, 9,   0,       4'b1000, 1, 16'h1111, 0, 16'h2222, 0, 5,  16'h1111);
    tbl[1]  = mk(1, 1, 7,   16'hAAAA, 1, 1, 7,  16'hBBBB, 4'b0001, 0, 0,        0, 0,        0, 7,  16'hBBBB);
    tbl[2]  = mk(1, 1, 3,   16'h1234, 1, 0, 3,  0,       4'b0100, 0, 0,        0, 16'h1234, 0, 3,  16'h1234);
    tbl[3]  = mk(1, 0, 4,   0,       1, 1, 4,   16'h5555, 4'b1000, 1, 16'h0F0F, 0, 0,        0, 4,  16'h5555);
    tbl[4]  = mk(1, 0, 600, 0,       0, 0, 0,   0,       4'b0000, 0, 0,        1, 0,        0, 5,  16'h1111);
    tbl[5]  = mk(1, 0, 5,   0,       1, 0, 5,   0,       4'b1000, 0, 16'h1111, 0, 16'h1111, 0, 5,  16'h1111);
    tbl[6]  = mk(1, 0, 5,   0,       1, 1, 9,   16'h7777, 4'b1001, 0, 16'h1111, 0, 0,        0, 9,  16'h7777);
    tbl[7]  = mk(0, 0, 0,   0,       1, 0, 9,   0,       4'b0010, 0, 0,        0, 16'h2222, 0, 9,  16'h2222);
    tbl[8]  = mk(1, 1, 20,  16'h3333, 1, 1, 21, 16'h4444, 4'b0101, 0, 0,        0, 0,        0, 21, 16'h4444);
    tbl[9]  = mk(1, 0, 511, 0,       1, 0, 512, 0,       4'b1000, 0, 16'h06FD, 0, 0,        1, 5,  16'h1111);
    tbl[10] = mk(1, 1, 600, 16'hDEAD, 1, 0, 9,  0,       4'b0010, 0, 0,        1, 16'h2222, 0, 5,  16'h1111);
    tbl[11] = mk(1, 0, 12,  0,       0, 0, 0,   0,       4'b1000, 0, 16'h0124, 0, 0,        0, 12, 16'h0124);
    tbl[12] = mk(0, 0, 0,   0,       1, 1, 30,  16'hCAFE, 4'b0001, 0, 0,        0, 0,        0, 30, 16'hCAFE);

    // Reset behaviour, including a request offered while reset is low.
    init_mem();
    @(posedge clock); #1;
    chk("rst_state", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 6'b0);
    chk("rst_rdata", {rsp0_rdata, rsp1_rdata}, 32'h0);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'd5;
    #1;
    chk("rst_no_strobe", {mem_read0, mem_write0}, 2'b00);
    @(posedge clock); #1;
    chk("rst_no_accept", rsp0_valid, 1'b0);
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_release_ready", {req0_ready, req1_ready}, 2'b11);
    @(posedge clock); #1;

    foreach (tbl[i]) begin
      init_mem();
      do_txn(tbl[i], 1'b1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.mem", i), mem[tbl[i].ca[8:0]], tbl[i].cv);
    end

    // Reset arriving during HOLD drops the held pipe-1 load.
    init_mem();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'd5;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'd9;
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("hold_rst_strobe", {mem_read1, mem_write1, req0_ready, req1_ready}, 4'b0000);
    @(posedge clock); #1;
    chk("hold_rst_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    reset = 1'b1;
    #1;
    chk("hold_rst_ready", {req0_ready, req1_ready}, 2'b11);
    @(posedge clock); #1;
    chk("hold_rst_after", {rsp1_valid, mem_read1, mem_write1}, 3'b000);

    // Random pairs against the program-order model.
    init_mem();
    for (int i = 0; i < MEM_SIZE; i++) model_mem[i] = init_val(i);
    for (int n = 0; n < 300; n++) begin
      vec_t v;
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 0);
      v.v0 = ($urandom_range(0, 4) != 0);
      v.v1 = ($urandom_range(0, 4) != 0);
      v.we0 = 1'($urandom_range(0, 1));
      v.we1 = 1'($urandom_range(0, 1));
      v.a0 = pick_addr();
      v.a1 = pick_addr();
      v.d0 = 16'($urandom);
      v.d1 = 16'($urandom);
      model_txn(v);
      do_txn(v, 1'b0, $sformatf("rnd%0d", n));
    end
    begin
      int bad = 0;
      for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== model_mem[i]) bad++;
      chk("mem_final_mismatches", bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_port_scheduler.md
DMEM_PORT_SCHEDULER -- requirements
Module: dmem_port_scheduler

Interface
REQ-001 Parameter MEM_SIZE, default 512: number of 16-bit words in the attached dual-port data memory.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req0_valid/req0_we  input  1 each  pipe-0 (older) access request; we=1 store, we=0 load.
REQ-005 req0_addr/req0_wdata  input  16 each  pipe-0 word address and store data.
REQ-006 req0_ready  output  1  pipe-0 request accepted when valid and ready are both high.
REQ-007 req1_valid, req1_we, req1_addr, req1_wdata, req1_ready: same widths and meaning for pipe 1 (younger).
REQ-008 rsp0_valid  output  1; rsp0_rdata  output  16; rsp0_err  output  1: pipe-0 completion, load data, and out-of-range flag.
REQ-009 rsp1_valid, rsp1_rdata, rsp1_err: same for pipe 1.
REQ-010 mem_address0/mem_address1  output  16; mem_read0, mem_read1, mem_write0, mem_write1  output  1; mem_wdata0/mem_wdata1  output  16; mem_rdata0/mem_rdata1  input  16: memory port 0/1 controls and data.

Function
REQ-011 States: IDLE and HOLD only.
REQ-012 req0_ready and req1_ready SHALL be 1 in IDLE and 0 in HOLD or while reset is low.
REQ-013 Memory-side outputs SHALL be combinational from the accepted requests (IDLE) or the hold register (HOLD); all unused controls 0.
REQ-014 mem_read0 and mem_read1 SHALL never be high in the same cycle.
REQ-015 Address out of range (addr >= MEM_SIZE): no memory strobe for that pipe; response returned with err=1 and rdata=0.
REQ-016 No conflict: each pipe is issued on its own port (pipe n -> port n) in the acceptance cycle.
REQ-017 Both stores, same address: only mem_write1 issued with req1_wdata; both pipes respond.
REQ-018 Pipe-0 store, pipe-1 load, same address: only mem_write0 issued; rsp1_rdata = req0_wdata (forwarded).
REQ-019 Both loads, same address: only mem_read0 issued; rsp0_rdata and rsp1_rdata both = mem_rdata0.
REQ-020 Both loads at different addresses, or pipe-0 load and pipe-1 store at the same address: split. Pipe 0 is issued; pipe 1 is captured in the hold register; go to HOLD.
REQ-021 HOLD: issue the held pipe-1 operation on port 1, then return to IDLE unconditionally in the next cycle.
REQ-022 Latency: rsp_valid is asserted exactly one cycle after the operation issues, with rdata registered from mem_rdata of the issuing port; it is a single-cycle pulse.
REQ-023 Stores SHALL also produce an rsp_valid pulse with rdata=0.
REQ-024 A single valid request (either pipe) is issued without split.
REQ-025 Order: pipe 0 is never observed after pipe 1. Split ordering SHALL guarantee a pipe-0 load reads the value from before a same-address pipe-1 store.

Reset
REQ-026 While reset is low at a rising edge: state <= IDLE; hold register invalid; all rsp_valid, rsp_rdata and rsp_err <= 0.
REQ-027 Reset asserted in HOLD SHALL discard the held request: no memory strobe and no response.
REQ-028 Requests presented while reset is low are not accepted.

Structure
REQ-029 Shared package dmem_sched_pkg SHALL hold the state enum, the MEM_SIZE default and the conflict-class enum (NONE, WW_SAME, WR_FWD, RR_SAME, SPLIT).
REQ-030 Sub-module dmem_conflict_detect (combinational) SHALL classify the two requests into a conflict class; the top SHALL hold the FSM, hold register and response registers.

Verification
REQ-031 Loads pipe0 addr 5 and pipe1 addr 9, memory holding 0x1111/0x2222 -> cycle 0 read0@5, cycle 1 read1@9 (HOLD, readies 0), rsp0 0x1111 at cycle 1, rsp1 0x2222 at cycle 2.
REQ-032 Stores pipe0 0xAAAA@7 and pipe1 0xBBBB@7 -> only write1 asserted, mem[7]=0xBBBB, both rsp_valid next cycle.
REQ-033 Pipe0 store 0x1234@3 with pipe1 load @3 -> write0 only, no read strobe, rsp1_rdata=0x1234 next cycle.
REQ-034 Pipe0 load @4 (old 0x0F0F) with pipe1 store 0x5555@4 -> rsp0_rdata=0x0F0F, mem[4]=0x5555 after HOLD.
REQ-035 Pipe0 load @600 with MEM_SIZE=512 -> no strobe, rsp0_err=1, rsp0_rdata=0.
REQ-036 Reset low during HOLD -> no port-1 strobe, no rsp1_valid, IDLE with readies 1 after reset release.
